// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters, with a one-entry
// response buffer. Defining ALU_ARB_OPCHECK_EN zeroes results of opcodes above MAX_OP and adds rsp_err.
module alu_share_arbiter #(
    parameter int              DATA_W = 32,
    parameter int              OP_W   = 5,
    parameter logic [OP_W-1:0] MAX_OP = 5'b01010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [OP_W-1:0]   r0_req_op,
    input  logic [DATA_W-1:0] r0_req_a,
    input  logic [DATA_W-1:0] r0_req_b,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [OP_W-1:0]   r1_req_op,
    input  logic [DATA_W-1:0] r1_req_a,
    input  logic [DATA_W-1:0] r1_req_b,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
`ifdef ALU_ARB_OPCHECK_EN
    output logic              rsp_err,
`endif
    input  logic [DATA_W-1:0] alu_result
);

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [OP_W-1:0]   req_op [2];
    logic [DATA_W-1:0] req_a  [2];
    logic [DATA_W-1:0] req_b  [2];

    logic              pend_reg,  pend_next;
    logic              owner_reg, owner_next;
    logic              prio_reg,  prio_next;
    logic [DATA_W-1:0] rsp_reg,   rsp_next;
`ifdef ALU_ARB_OPCHECK_EN
    logic              err_reg,   err_next;
`endif

    logic grant_valid;
    logic grant_idx;
    logic drain;
    logic can_accept;
    logic accept;

    assign req_valid = {r1_req_valid, r0_req_valid};
    assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};
    assign req_op[0] = r0_req_op;
    assign req_op[1] = r1_req_op;
    assign req_a[0]  = r0_req_a;
    assign req_a[1]  = r1_req_a;
    assign req_b[0]  = r0_req_b;
    assign req_b[1]  = r1_req_b;

    // Tie goes to prio; a lone requester wins regardless of prio.
    always_comb begin
        grant_valid = |req_valid;
        grant_idx   = (&req_valid) ? prio_reg : req_valid[1];
    end

    // The buffer can be refilled in the same cycle its owner drains it.
    assign drain      = pend_reg && rsp_ready[owner_reg];
    assign can_accept = !pend_reg || drain;
    assign accept     = can_accept && grant_valid;

    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (grant_valid) begin
            alu_op = req_op[grant_idx];
            alu_a  = req_a[grant_idx];
            alu_b  = req_b[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg  <= 1'b0;
            owner_reg <= 1'b0;
            prio_reg  <= 1'b0;
            rsp_reg   <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            pend_reg  <= pend_next;
            owner_reg <= owner_next;
            prio_reg  <= prio_next;
            rsp_reg   <= rsp_next;
`ifdef ALU_ARB_OPCHECK_EN
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        pend_next  = pend_reg;
        owner_next = owner_reg;
        prio_next  = prio_reg;
        rsp_next   = rsp_reg;
`ifdef ALU_ARB_OPCHECK_EN
        err_next   = err_reg;
`endif
        if (accept) begin
            pend_next  = 1'b1;
            owner_next = grant_idx;
            prio_next  = ~grant_idx;
            rsp_next   = alu_result;
`ifdef ALU_ARB_OPCHECK_EN
            // alu_op already carries the granted opcode.
            err_next   = (alu_op > MAX_OP);
            if (alu_op > MAX_OP) begin
                rsp_next = '0;
            end
`endif
        end else if (drain) begin
            pend_next = 1'b0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi] = accept && (grant_idx == 1'(gi));
        assign rsp_valid[gi] = pend_reg && (owner_reg == 1'(gi));
    end

    assign r0_req_ready = req_ready[0];
    assign r1_req_ready = req_ready[1];
    assign r0_rsp_valid = rsp_valid[0];
    assign r1_rsp_valid = rsp_valid[1];
    assign rsp_data     = rsp_reg;
`ifdef ALU_ARB_OPCHECK_EN
    assign rsp_err      = pend_reg && err_reg;
`endif

endmodule
